// File: rtl/hdmi_video_timing.sv
// rtl/hdmi_video_timing.sv - lock-gated raster timing generator (hsync/vsync/de/x/y)
//
// Ports:
//   clk          pixel clock
//   resetn       asynchronous active-low reset
//   pll_locked   PLL lock indication, asynchronous to clk
//   hsync        horizontal sync, active level HS_POL
//   vsync        vertical sync, active level VS_POL
//   de           data enable, high in the active area
//   x, y         pixel coordinates of the current cycle
//   line_start   one-cycle pulse on x == 0 while running
//   frame_start  one-cycle pulse on x == 0 && y == 0 while running
//   running      high while the raster is being generated
module hdmi_video_timing #(
    parameter int H_ACTIVE      = 640,
    parameter int H_FP          = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BP          = 48,
    parameter int V_ACTIVE      = 480,
    parameter int V_FP          = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BP          = 33,
    parameter bit HS_POL        = 1'b0,
    parameter bit VS_POL        = 1'b0,
    parameter int SETTLE_CYCLES = 1024,
    parameter int COORD_W       = 12
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               pll_locked,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               line_start,
    output logic               frame_start,
    output logic               running
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int SW      = $clog2(SETTLE_CYCLES + 1);

    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [SW-1:0]      S_LAST   = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        SETTLE,
        RUN
    } state_t;

    state_t          state;
    logic [SW-1:0]   settle_cnt;
    logic            lk_meta;
    logic            lk_s;
    logic            run_next;
    logic [COORD_W-1:0] px;
    logic [COORD_W-1:0] py;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lk_meta <= 1'b0;
            lk_s    <= 1'b0;
        end else begin
            lk_meta <= pll_locked;
            lk_s    <= lk_meta;
        end
    end

    // Pixel the outputs will describe after this edge. Entering RUN starts
    // at (0,0); otherwise the raster advances from the registered x/y.
    always_comb begin
        px = '0;
        py = '0;
        if (state == RUN) begin
            if (x == H_LAST) begin
                px = '0;
                py = (y == V_LAST) ? '0 : y + COORD_W'(1);
            end else begin
                px = x + COORD_W'(1);
                py = y;
            end
        end
    end

    // High when the state after this edge is RUN.
    always_comb begin
        run_next = 1'b0;
        case (state)
            WAIT_LOCK: run_next = lk_s && (SETTLE_CYCLES == 1);
            SETTLE:    run_next = lk_s && (settle_cnt == S_LAST);
            RUN:       run_next = lk_s;
            default:   run_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= WAIT_LOCK;
            settle_cnt  <= '0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            running     <= 1'b0;
        end else begin
            // settle_cnt is the index of the current locked cycle; the cycle
            // that leaves WAIT_LOCK is locked cycle 0, so SETTLE resumes at 1.
            case (state)
                WAIT_LOCK: begin
                    settle_cnt <= '0;
                    if (lk_s) begin
                        if (SETTLE_CYCLES == 1) begin
                            state <= RUN;
                        end else begin
                            state      <= SETTLE;
                            settle_cnt <= SW'(1);
                        end
                    end
                end
                SETTLE: begin
                    if (!lk_s) begin
                        state      <= WAIT_LOCK;
                        settle_cnt <= '0;
                    end else if (settle_cnt == S_LAST) begin
                        state      <= RUN;
                        settle_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                end
                RUN: begin
                    settle_cnt <= '0;
                    if (!lk_s) begin
                        state <= WAIT_LOCK;
                    end
                end
                default: begin
                    state      <= WAIT_LOCK;
                    settle_cnt <= '0;
                end
            endcase

            // All outputs decode the same next pixel, so they stay aligned.
            if (run_next) begin
                x           <= px;
                y           <= py;
                de          <= (px < H_ACT) && (py < V_ACT);
                hsync       <= ((px >= HS_START) && (px < HS_END)) ? HS_POL : ~HS_POL;
                vsync       <= ((py >= VS_START) && (py < VS_END)) ? VS_POL : ~VS_POL;
                line_start  <= (px == '0);
                frame_start <= (px == '0) && (py == '0);
                running     <= 1'b1;
            end else begin
                x           <= '0;
                y           <= '0;
                de          <= 1'b0;
                hsync       <= ~HS_POL;
                vsync       <= ~VS_POL;
                line_start  <= 1'b0;
                frame_start <= 1'b0;
                running     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hdmi_video_timing.sv
// tb/tb_hdmi_video_timing.sv - self-checking bench for hdmi_video_timing
module tb_hdmi_video_timing;

    localparam int HA  = 16;
    localparam int HF  = 4;
    localparam int HS  = 6;
    localparam int HB  = 6;
    localparam int VA  = 10;
    localparam int VF  = 2;
    localparam int VSW = 2;
    localparam int VB  = 3;
    localparam int S   = 20;
    localparam int CW  = 12;
    localparam int HT  = HA + HF + HS + HB;
    localparam int VT  = VA + VF + VSW + VB;
    localparam bit HSP = 1'b0;
    localparam bit VSP = 1'b0;

    logic          clk;
    logic          resetn;
    logic          pll_locked;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          line_start;
    logic          frame_start;
    logic          running;

    hdmi_video_timing #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(HSP), .VS_POL(VSP), .SETTLE_CYCLES(S), .COORD_W(CW)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .pll_locked(pll_locked),
        .hsync(hsync),
        .vsync(vsync),
        .de(de),
        .x(x),
        .y(y),
        .line_start(line_start),
        .frame_start(frame_start),
        .running(running)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the raster is a pure function of how many consecutive
    // synchronized-locked cycles have been seen. Once that streak reaches S,
    // the pixel index is streak-S and x/y follow from division by the totals.
    bit s1 = 1'b0;
    bit s2 = 1'b0;
    int streak = 0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1 = 1'b0;
            s2 = 1'b0;
            streak = 0;
        end else begin
            if (s2) streak++;
            else streak = 0;
            s2 = s1;
            s1 = pll_locked;
        end
    end

    localparam logic [29:0] RESET_VEC = {4'b0000, ~HSP, ~VSP, 12'd0, 12'd0};

    function automatic logic [29:0] expect_vec(input int st);
        int p, ex, ey;
        bit hs_a, vs_a;
        if (st < S) return RESET_VEC;
        p  = st - S;
        ex = p % HT;
        ey = (p / HT) % VT;
        hs_a = (ex >= HA + HF) && (ex < HA + HF + HS);
        vs_a = (ey >= VA + VF) && (ey < VA + VF + VSW);
        return {1'b1, ex == 0, (ex == 0) && (ey == 0), (ex < HA) && (ey < VA),
                hs_a ? HSP : ~HSP, vs_a ? VSP : ~VSP, 12'(ex), 12'(ey)};
    endfunction

    logic [29:0] dut_vec;
    assign dut_vec = {running, line_start, frame_start, de, hsync, vsync, x, y};

    always @(negedge clk) begin
        check("raster", 64'(dut_vec), 64'(expect_vec(streak)));
    end

    // Edges until the chosen output first reads 1 (0 if never within bound).
    task automatic count_to(input string tag, input bit want_frame, input int exp);
        int n = 0;
        bit seen = 1'b0;
        for (int i = 1; i <= 4000 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (want_frame ? frame_start : running) begin
                n = i;
                seen = 1'b1;
            end
        end
        check(tag, 64'(n), 64'(exp));
    endtask

    // Called at the first cycle of a frame; profiles one whole frame.
    task automatic measure_frame();
        int de_cnt = 0, hs_cnt = 0, vs_cnt = 0, fs_cnt = 0, fs_last = -1;
        int ls_second = -1, ls_cnt = 0;
        int hs_x = -1;
        logic [23:0] vs_xy = '1;
        for (int i = 0; i <= HT * VT; i++) begin
            if (i < HT * VT) begin
                if (de) de_cnt++;
                if (hsync == HSP) begin
                    hs_cnt++;
                    if (hs_x < 0) hs_x = int'(x);
                end
                if (vsync == VSP) begin
                    if (vs_cnt == 0) vs_xy = {x, y};
                    vs_cnt++;
                end
            end
            if (frame_start) begin
                fs_cnt++;
                fs_last = i;
            end
            if (line_start) begin
                ls_cnt++;
                if (ls_cnt == 2) ls_second = i;
            end
            @(posedge clk);
            #1;
        end
        check("de_count", 64'(de_cnt), 64'(HA * VA));
        check("hsync_count", 64'(hs_cnt), 64'(HS * VT));
        check("hsync_first_x", 64'(hs_x), 64'(HA + HF));
        check("vsync_count", 64'(vs_cnt), 64'(VSW * HT));
        check("vsync_first_xy", 64'(vs_xy), 64'({12'd0, 12'(VA + VF)}));
        check("line_period", 64'(ls_second), 64'(HT));
        check("frame_count", 64'(fs_cnt), 64'(2));
        check("frame_period", 64'(fs_last), 64'(HT * VT));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bit found;
        resetn = 1'b1;
        pll_locked = 1'b1;
        #1 resetn = 1'b0;
        #2 check("reset_state", 64'(dut_vec), 64'(RESET_VEC));

        // Startup with lock present from the first cycle.
        @(posedge clk);
        @(posedge clk);
        #1 resetn = 1'b1;
        count_to("startup_latency", 1'b0, S + 2);
        check("startup_pixel", 64'({frame_start, de, x, y}), 64'({2'b11, 24'd0}));

        measure_frame();

        // Lose lock, then a short dropout partway through settling.
        pll_locked = 1'b0;
        repeat (6) @(posedge clk);
        #1 check("idle_after_drop", 64'(running), 64'(0));
        pll_locked = 1'b1;
        repeat (S / 2) @(posedge clk);
        #1 pll_locked = 1'b0;
        repeat (3) @(posedge clk);
        #1 pll_locked = 1'b1;
        count_to("glitch_relock", 1'b0, S + 2);

        // Lock loss in the middle of the active area.
        found = 1'b0;
        for (int i = 0; i < 2 * HT * VT && !found; i++) begin
            if (running && x == CW'(7) && y == CW'(5)) found = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("reach_mid_frame", 64'(found), 64'(1));
        pll_locked = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("lock_loss_outputs", 64'(dut_vec), 64'(RESET_VEC));
        pll_locked = 1'b1;
        count_to("relock_frame", 1'b1, S + 2);

        // Random lock behaviour; the continuous model check covers it.
        for (int k = 0; k < 40; k++) begin
            pll_locked = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(1, S + 2 * HT)) @(posedge clk);
            #1;
        end

        // Async reset pulse between clock edges, mid-line.
        pll_locked = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 4 * HT * VT && !found; i++) begin
            @(posedge clk);
            #1;
            if (running && x == CW'(10)) found = 1'b1;
        end
        check("reach_mid_line", 64'(found), 64'(1));
        #1 resetn = 1'b0;
        #1 check("async_reset", 64'(dut_vec), 64'(RESET_VEC));
        #1 resetn = 1'b1;
        count_to("restart_latency", 1'b0, S + 2);
        check("restart_pixel", 64'({frame_start, x, y}), 64'({1'b1, 24'd0}));

        repeat (HT * 3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hdmi_video_timing.md
Name: hdmi_video_timing

Overview:
- Raster timing generator clocked by the 25 MHz pixel clock from the HDMI PLL.
- Produces hsync, vsync, data-enable and pixel coordinates for the TMDS encoder and pixel source.
- Gates itself on the PLL lock indication: no sync activity until lock has been stable for a set time.
- Stops cleanly if lock is lost.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level
- SETTLE_CYCLES, 1024, consecutive locked cycles required before running (≥1)
- COORD_W, 12, width of x/y outputs

Ports:
- clk  in  1  pixel clock (PLL 25 MHz output)
- resetn  in  1  asynchronous active-low reset
- pll_locked  in  1  PLL lock, asynchronous to clk
- hsync  out  1  horizontal sync, polarity per HS_POL
- vsync  out  1  vertical sync, polarity per VS_POL
- de  out  1  data enable, high in active area
- x  out  COORD_W  horizontal counter, 0..H_TOTAL-1
- y  out  COORD_W  vertical counter, 0..V_TOTAL-1
- line_start  out  1  one-cycle pulse when x==0 while running
- frame_start  out  1  one-cycle pulse when x==0 && y==0 while running
- running  out  1  high in RUN state

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL likewise (default 525).
- pll_locked passes through a 2-FF synchronizer (lk_s); both flops reset to 0.
- Reset values of all outputs:
  - hsync = ~HS_POL, vsync = ~VS_POL
  - de = 0, x = 0, y = 0
  - line_start = 0, frame_start = 0, running = 0
  - Internal state = WAIT_LOCK, settle counter = 0.
- FSM:
  - WAIT_LOCK: settle counter = 0. lk_s = 1 → SETTLE.
  - SETTLE: counter increments each cycle lk_s = 1. lk_s = 0 → WAIT_LOCK (counter cleared). Counter reaching SETTLE_CYCLES-1 with lk_s = 1 → RUN.
  - RUN: h/v counters advance. lk_s = 0 → WAIT_LOCK.
- Outputs outside RUN: held at their reset values.
- Counters:
  - h increments each RUN cycle and wraps H_TOTAL-1 → 0.
  - On wrap, v increments and wraps V_TOTAL-1 → 0.
- First RUN cycle: x = 0, y = 0, de = 1, line_start = 1, frame_start = 1, running = 1.
- Alignment: all outputs registered. hsync, vsync, de, x, y and the pulses in a given cycle all describe the same pixel (x, y); no skew between them.
- Decodes:
  - de = (x < H_ACTIVE) && (y < V_ACTIVE)
  - hsync active when H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC
  - vsync active when V_ACTIVE+V_FP ≤ y < V_ACTIVE+V_FP+V_SYNC; changes only on cycles where x = 0
- Lock loss in RUN:
  - The cycle after lk_s is sampled 0, all outputs return to reset values and counters clear.
  - No partial line or frame is resumed; the next RUN starts at (0,0) after a full SETTLE.
- Async resetn assertion at any time forces reset values immediately, without waiting for a clock edge. Deassertion resumes from WAIT_LOCK.
- pll_locked glitches shorter than one clk cycle may or may not be seen; any sampled 0 is honoured.
- Counter widths: COORD_W must hold H_TOTAL-1 and V_TOTAL-1. The settle counter is sized by $clog2(SETTLE_CYCLES+1).

Test Plan:
- Startup: resetn released, pll_locked = 1 from cycle 0 → running rises and frame_start pulses exactly 2+SETTLE_CYCLES (1026) cycles later, with x = 0, y = 0, de = 1.
- Horizontal: in RUN, over one line → de high for 640 cycles, hsync low for 96 cycles starting at x = 656, line_start period 800 cycles.
- Vertical: over one frame → vsync low exactly during lines 490–491 (1600 cycles), starting on the x = 0 cycle; de high on 480 lines; frame_start period 420000 cycles.
- Settle glitch: pll_locked low for 3 cycles after 500 settle cycles → settle restarts; running rises 1026 cycles after pll_locked returns high.
- Lock loss mid-frame at (x = 300, y = 200): within 3 cycles de = 0, hsync = 1, vsync = 1, running = 0, x = y = 0. Relock → the next frame_start arrives only after a full settle period.
- Async reset: resetn pulsed low mid-line (no clock edge during the low) → outputs at reset values immediately. After release, normal startup sequence as in the first scenario.
